// File: rtl/nq_bus_pkg.sv
// Shared types and constants for the memory-bus arbiter slice.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package nq_bus_pkg;

    // Arbiter FSM states; the encoding is exported on dbg_state.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_F = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_TURN   = 2'd3
    } bus_state_t;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;

    // Read data returned on a timeout abort; sliced down to DATA_W by users.
    localparam logic [63:0] ERR_RDATA = '1;

endpackage

// File: rtl/mem_arb_pick.sv
// Fixed-priority pick (data over fetch) with a fetch starvation guard.
// Latency: grants are combinational; starvation count updates on the grant edge.
// Backpressure: none; grants are only consumed when grant_stb is high.
module mem_arb_pick #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic fetch_req,
    input  logic data_req,
    input  logic grant_stb,
    output logic grant_data,
    output logic grant_fetch
);

    localparam int              SW    = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   S_MAX = SW'(STARVE_MAX);

    logic [SW-1:0] r_starve_cnt;
    logic          w_starved;

    assign w_starved   = (r_starve_cnt == S_MAX);
    // Fetch wins when data is absent, or when fetch has lost too many times in a row.
    assign grant_fetch = fetch_req & (~data_req | w_starved);
    assign grant_data  = data_req & ~grant_fetch;

    // Count consecutive arbitrations fetch lost to data; saturate, clear on a fetch win.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve_cnt <= '0;
        end else if (grant_stb) begin
            if (grant_fetch) begin
                r_starve_cnt <= '0;
            end else if (grant_data && fetch_req && !w_starved) begin
                r_starve_cnt <= r_starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch and data requesters, with timeout abort.
// Latency: mem_req 1 cycle after a request is sampled in IDLE; done 1 cycle after mem_ready.
// Backpressure: requesters hold req until done; needWait stalls the control unit meanwhile.
module mem_bus_arbiter
    import nq_bus_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic              fetch_done,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              needWait,
    output logic              bus_err,
    output logic [1:0]        dbg_state
);

    localparam int                TW          = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]     TMO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] L_ERR_RDATA = ERR_RDATA[DATA_W-1:0];

    bus_state_t        r_state, w_state_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0] r_fetch_rdata, w_fetch_rdata_nxt;
    logic [DATA_W-1:0] r_data_rdata, w_data_rdata_nxt;
    logic              r_fetch_done, w_fetch_done_nxt;
    logic              r_data_done, w_data_done_nxt;
    logic              r_bus_err, w_bus_err_nxt;
    logic [TW-1:0]     r_tmo, w_tmo_nxt;
    logic [DATA_W-1:0] w_rsp_data;
    logic              w_grant_data, w_grant_fetch, w_grant_stb;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .data_req    (data_req),
        .grant_stb   (w_grant_stb),
        .grant_data  (w_grant_data),
        .grant_fetch (w_grant_fetch)
    );

    // State and registered outputs; async reset drops mem_req mid-transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_fetch_rdata <= '0;
            r_data_rdata  <= '0;
            r_fetch_done  <= 1'b0;
            r_data_done   <= 1'b0;
            r_bus_err     <= 1'b0;
            r_tmo         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_fetch_rdata <= w_fetch_rdata_nxt;
            r_data_rdata  <= w_data_rdata_nxt;
            r_fetch_done  <= w_fetch_done_nxt;
            r_data_done   <= w_data_done_nxt;
            r_bus_err     <= w_bus_err_nxt;
            r_tmo         <= w_tmo_nxt;
        end
    end

    // Next-state: grant in IDLE, wait for mem_ready or timeout in BUSY, one turnaround cycle.
    always_comb begin
        w_state_nxt       = r_state;
        w_mem_req_nxt     = r_mem_req;
        w_mem_we_nxt      = r_mem_we;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_wdata_nxt   = r_mem_wdata;
        w_fetch_rdata_nxt = r_fetch_rdata;
        w_data_rdata_nxt  = r_data_rdata;
        w_fetch_done_nxt  = 1'b0;
        w_data_done_nxt   = 1'b0;
        w_bus_err_nxt     = 1'b0;
        w_tmo_nxt         = r_tmo;
        w_grant_stb       = 1'b0;
        w_rsp_data        = mem_ready ? mem_rdata : L_ERR_RDATA;
        case (r_state)
            ST_IDLE: begin
                if (w_grant_data || w_grant_fetch) begin
                    w_grant_stb   = 1'b1;
                    w_mem_req_nxt = 1'b1;
                    w_tmo_nxt     = '0;
                    if (w_grant_data) begin
                        w_mem_we_nxt    = data_we;
                        w_mem_addr_nxt  = data_addr;
                        w_mem_wdata_nxt = data_wdata;
                        w_state_nxt     = ST_BUSY_D;
                    end else begin
                        w_mem_we_nxt   = 1'b0;
                        w_mem_addr_nxt = fetch_addr;
                        w_state_nxt    = ST_BUSY_F;
                    end
                end
            end
            ST_BUSY_F, ST_BUSY_D: begin
                if (mem_ready || (r_tmo == TMO_LAST)) begin
                    if (r_state == ST_BUSY_F) begin
                        w_fetch_rdata_nxt = w_rsp_data;
                        w_fetch_done_nxt  = 1'b1;
                    end else begin
                        w_data_rdata_nxt = w_rsp_data;
                        w_data_done_nxt  = 1'b1;
                    end
                    w_bus_err_nxt = ~mem_ready;
                    w_mem_req_nxt = 1'b0;
                    w_tmo_nxt     = '0;
                    w_state_nxt   = ST_TURN;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            ST_TURN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign fetch_rdata = r_fetch_rdata;
    assign fetch_done  = r_fetch_done;
    assign data_rdata  = r_data_rdata;
    assign data_done   = r_data_done;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign bus_err     = r_bus_err;
    assign dbg_state   = r_state;
    // Stall while a request is pending and its done pulse has not yet arrived.
    assign needWait    = (fetch_req & ~r_fetch_done) | (data_req & ~r_data_done);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int AW   = 16;
    localparam int DW   = 16;
    localparam int SMAX = 4;
    localparam int TMO  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fetch_req;
    logic [AW-1:0] fetch_addr;
    logic [DW-1:0] fetch_rdata;
    logic          fetch_done;
    logic          data_req;
    logic          data_we;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic [DW-1:0] data_rdata;
    logic          data_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          needWait;
    logic          bus_err;
    logic [1:0]    dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_rdata(fetch_rdata), .fetch_done(fetch_done),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_done(data_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .needWait(needWait), .bus_err(bus_err), .dbg_state(dbg_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory responder for directed tests: waits for mem_req, asserts mem_ready in busy cycle lat.
    task automatic serve(input int lat, input logic [DW-1:0] rd, output int owner, output bit ok);
        ok = 1'b0;
        owner = 0;
        for (int i = 0; i < 30; i++) begin
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) return;
        owner = int'(dbg_state);
        repeat (lat - 1) step();
        mem_ready = 1'b1;
        mem_rdata = rd;
        step();
        mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        fetch_req = 1'b0; fetch_addr = '0;
        data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_wdata = '0;
        mem_rdata = '0; mem_ready = 1'b0;
        repeat (3) step();
        n_tests++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_mem got=%h exp=0", {mem_req, mem_we, mem_addr, mem_wdata});
        end
        n_tests++;
        if ({fetch_done, data_done, bus_err, needWait} !== 4'b0) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=0000", {fetch_done, data_done, bus_err, needWait});
        end
        n_tests++;
        if ({fetch_rdata, data_rdata} !== '0) begin
            n_fail++; $display("FAIL reset_rdata got=%h exp=0", {fetch_rdata, data_rdata});
        end
        n_tests++;
        if (dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if (mem_req !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL reset_idle got=%b/%0d exp=0/0", mem_req, dbg_state);
        end
    endtask

    task automatic test_single_fetch();
        fetch_addr = 16'h0010;
        fetch_req  = 1'b1;
        #1;
        n_tests++;
        if (needWait !== 1'b1) begin
            n_fail++; $display("FAIL fetch_nw_start got=%b exp=1", needWait);
        end
        step();
        n_tests++;
        if ({mem_req, mem_we, mem_addr, dbg_state} !== {1'b1, 1'b0, 16'h0010, 2'd1}) begin
            n_fail++; $display("FAIL fetch_grant got=%b/%b/%h/%0d exp=1/0/0010/1", mem_req, mem_we, mem_addr, dbg_state);
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            n_tests++;
            if ({mem_req, needWait, fetch_done} !== 3'b110) begin
                n_fail++; $display("FAIL fetch_busy%0d got=%b exp=110", i, {mem_req, needWait, fetch_done});
            end
        end
        step();
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        step();
        mem_ready = 1'b0;
        n_tests++;
        if ({fetch_done, data_done, bus_err, mem_req, needWait} !== 5'b10000 || fetch_rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL fetch_done got=%b rd=%h exp=10000 rd=beef", {fetch_done, data_done, bus_err, mem_req, needWait}, fetch_rdata);
        end
        fetch_req = 1'b0;
        step();
        n_tests++;
        if (fetch_done !== 1'b0 || dbg_state !== 2'd0 || fetch_rdata !== 16'hBEEF) begin
            n_fail++; $display("FAIL fetch_after got=%b/%0d/%h exp=0/0/beef", fetch_done, dbg_state, fetch_rdata);
        end
    endtask

    task automatic test_simultaneous();
        int k;
        data_we = 1'b1; data_addr = 16'h0200; data_wdata = 16'h1234;
        fetch_addr = 16'h0020;
        data_req = 1'b1; fetch_req = 1'b1;
        step();
        n_tests++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, dbg_state} !== {1'b1, 1'b1, 16'h0200, 16'h1234, 2'd2}) begin
            n_fail++; $display("FAIL sim_data_grant got=%b/%b/%h/%h/%0d", mem_req, mem_we, mem_addr, mem_wdata, dbg_state);
        end
        mem_ready = 1'b1; mem_rdata = 16'h5555;
        step();
        mem_ready = 1'b0;
        n_tests++;
        if ({data_done, fetch_done} !== 2'b10 || data_rdata !== 16'h5555) begin
            n_fail++; $display("FAIL sim_data_done got=%b rd=%h exp=10 rd=5555", {data_done, fetch_done}, data_rdata);
        end
        data_req = 1'b0;
        k = 0;
        for (int i = 1; i <= 6; i++) begin
            step();
            if (mem_req === 1'b1) begin
                k = i;
                break;
            end
        end
        n_tests++;
        if (k != 2 || mem_we !== 1'b0 || mem_addr !== 16'h0020 || dbg_state !== 2'd1) begin
            n_fail++; $display("FAIL sim_fetch_grant got=gap%0d/%b/%h/%0d exp=gap2/0/0020/1", k, mem_we, mem_addr, dbg_state);
        end
        mem_ready = 1'b1; mem_rdata = 16'h7777;
        step();
        mem_ready = 1'b0;
        n_tests++;
        if (fetch_done !== 1'b1 || fetch_rdata !== 16'h7777) begin
            n_fail++; $display("FAIL sim_fetch_done got=%b/%h exp=1/7777", fetch_done, fetch_rdata);
        end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_starve();
        int  starve = 0;
        int  want;
        int  owner;
        bit  ok;
        fetch_addr = 16'h0300; data_addr = 16'h0400; data_we = 1'b0;
        fetch_req = 1'b1; data_req = 1'b1;
        for (int g = 0; g < 10; g++) begin
            want = (starve == SMAX) ? 1 : 2;
            if (want == 1) starve = 0;
            else if (starve < SMAX) starve++;
            serve(1, DW'(g), owner, ok);
            n_tests++;
            if (!ok || owner != want) begin
                n_fail++; $display("FAIL starve_grant%0d got=%0d exp=%0d", g, owner, want);
            end
            if (!ok) break;
            if (g == 4) begin
                n_tests++;
                if (dut.u_pick.r_starve_cnt !== '0) begin
                    n_fail++; $display("FAIL starve_clear got=%0d exp=0", dut.u_pick.r_starve_cnt);
                end
            end
            if (owner == 1) fetch_req = 1'b0;
            else data_req = 1'b0;
            step();
            if (g < 9) begin
                fetch_req = 1'b1;
                data_req  = 1'b1;
            end
        end
        fetch_req = 1'b0; data_req = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        data_we = 1'b0; data_addr = 16'h0500;
        data_req = 1'b1;
        step();
        for (int i = 1; i <= TMO; i++) begin
            n_tests++;
            if ({mem_req, data_done, bus_err} !== 3'b100) begin
                n_fail++; $display("FAIL tmo_busy%0d got=%b exp=100", i, {mem_req, data_done, bus_err});
            end
            step();
        end
        n_tests++;
        if ({mem_req, data_done, bus_err} !== 3'b011 || data_rdata !== 16'hFFFF || dbg_state !== 2'd3) begin
            n_fail++; $display("FAIL tmo_abort got=%b rd=%h st=%0d exp=011 rd=ffff st=3", {mem_req, data_done, bus_err}, data_rdata, dbg_state);
        end
        data_req = 1'b0;
        step();
        n_tests++;
        if ({data_done, bus_err} !== 2'b00) begin
            n_fail++; $display("FAIL tmo_after got=%b exp=00", {data_done, bus_err});
        end
    endtask

    task automatic test_reset_mid();
        int owner;
        bit ok;
        data_we = 1'b1; data_addr = 16'h0600; data_wdata = 16'hAAAA;
        data_req = 1'b1;
        step();
        n_tests++;
        if (mem_req !== 1'b1 || dbg_state !== 2'd2) begin
            n_fail++; $display("FAIL rstmid_busy got=%b/%0d exp=1/2", mem_req, dbg_state);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (mem_req !== 1'b0 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL rstmid_async got=%b/%0d exp=0/0", mem_req, dbg_state);
        end
        data_req = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        n_tests++;
        if ({data_done, fetch_done, bus_err, mem_req} !== 4'b0 || dbg_state !== 2'd0) begin
            n_fail++; $display("FAIL rstmid_nodone got=%b/%0d exp=0000/0", {data_done, fetch_done, bus_err, mem_req}, dbg_state);
        end
        fetch_addr = 16'h0700;
        fetch_req = 1'b1;
        serve(2, 16'hC0DE, owner, ok);
        n_tests++;
        if (!ok || owner != 1 || fetch_done !== 1'b1 || fetch_rdata !== 16'hC0DE || mem_addr !== 16'h0700) begin
            n_fail++; $display("FAIL rstmid_fetch got=%0d/%b/%h exp=1/1/c0de", owner, fetch_done, fetch_rdata);
        end
        fetch_req = 1'b0;
        step();
    endtask

    // Random traffic from both requesters against a transaction-level model of arbitration.
    task automatic test_random(input int n_txn);
        int            done_cnt = 0;
        int            cyc = 0;
        int            starve = 0;
        int            owner = 0;
        int            want;
        int            lat = 0;
        int            busy = 0;
        bit            never = 1'b0;
        bit            exp_done = 1'b0;
        bit            just_done;
        bit            ok;
        logic          exp_err = 1'b0;
        logic          exp_nw;
        logic          ew;
        logic [AW-1:0] ea;
        logic [DW-1:0] exp_rd = '0;
        logic [DW-1:0] rd;
        fetch_req = 1'b0; data_req = 1'b0; mem_ready = 1'b0;
        while (done_cnt < n_txn && cyc < 3000) begin
            step();
            cyc++;
            just_done = 1'b0;
            exp_nw = (fetch_req && !(exp_done && owner == 1)) || (data_req && !(exp_done && owner == 2));
            n_tests++;
            if (needWait !== exp_nw || (!exp_done && {fetch_done, data_done, bus_err} !== 3'b000)) begin
                n_fail++; $display("FAIL rnd_cycle%0d nw=%b exp=%b done=%b", cyc, needWait, exp_nw, {fetch_done, data_done, bus_err});
            end
            if (exp_done) begin
                if (owner == 1) ok = (fetch_done === 1'b1) && (data_done === 1'b0) && (fetch_rdata === exp_rd);
                else ok = (data_done === 1'b1) && (fetch_done === 1'b0) && (data_rdata === exp_rd);
                ok = ok && (bus_err === exp_err) && (mem_req === 1'b0);
                n_tests++;
                if (!ok) begin
                    n_fail++; $display("FAIL rnd_done owner=%0d fd=%b dd=%b err=%b exp_err=%b frd=%h drd=%h exp_rd=%h",
                                       owner, fetch_done, data_done, bus_err, exp_err, fetch_rdata, data_rdata, exp_rd);
                end
                if (owner == 1) fetch_req = 1'b0;
                else data_req = 1'b0;
                owner = 0; exp_done = 1'b0; just_done = 1'b1;
                done_cnt++;
            end
            if (owner == 0 && mem_req === 1'b1) begin
                if (data_req && !(fetch_req && starve == SMAX)) want = 2;
                else if (fetch_req) want = 1;
                else want = 0;
                if (want == 2 && fetch_req && starve < SMAX) starve++;
                if (want == 1) starve = 0;
                if (want == 2) begin ew = data_we; ea = data_addr; end
                else begin ew = 1'b0; ea = fetch_addr; end
                n_tests++;
                if (dbg_state !== 2'(want) || mem_we !== ew || mem_addr !== ea ||
                    (want == 2 && data_we && mem_wdata !== data_wdata)) begin
                    n_fail++; $display("FAIL rnd_grant got=%0d/%b/%h exp=%0d/%b/%h", dbg_state, mem_we, mem_addr, want, ew, ea);
                end
                owner = (want == 0) ? 1 : want;
                lat = $urandom_range(1, 9);
                never = (lat == 9);
                busy = 0;
            end
            if (owner != 0 && !exp_done) begin
                busy++;
                n_tests++;
                if (mem_req !== 1'b1) begin
                    n_fail++; $display("FAIL rnd_mreq busy=%0d got=%b exp=1", busy, mem_req);
                end
                if (!never && busy == lat) begin
                    rd = DW'($urandom);
                    mem_ready = 1'b1; mem_rdata = rd;
                    exp_rd = rd; exp_err = 1'b0; exp_done = 1'b1;
                end else if (never && busy == TMO) begin
                    mem_ready = 1'b0; mem_rdata = DW'($urandom);
                    exp_rd = '1; exp_err = 1'b1; exp_done = 1'b1;
                end else begin
                    mem_ready = 1'b0; mem_rdata = DW'($urandom);
                end
            end else if (!exp_done) begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = DW'($urandom);
            end
            if (!fetch_req && !(just_done && owner == 0 && fetch_done === 1'b1) && $urandom_range(0, 2) == 0) begin
                fetch_req = 1'b1; fetch_addr = AW'($urandom);
            end
            if (!data_req && !(just_done && data_done === 1'b1) && $urandom_range(0, 2) == 0) begin
                data_req = 1'b1; data_we = 1'($urandom_range(0, 1));
                data_addr = AW'($urandom); data_wdata = DW'($urandom);
            end
        end
        n_tests++;
        if (done_cnt < n_txn) begin
            n_fail++; $display("FAIL rnd_budget got=%0d exp=%0d transactions", done_cnt, n_txn);
        end
        fetch_req = 1'b0; data_req = 1'b0; mem_ready = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starve();
        test_timeout();
        test_reset_mid();
        test_random(80);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

endmodule
